// File: rtl/display_scan_controller.sv
// ---------------------------------------------------------------------------
// display_scan_controller
//
// Purpose:
//   Time-multiplexes a 16-bit value and four decimal points onto a 4-digit
//   display, one digit per slot, for a downstream binary-to-hex decoder.
//   New values are double-buffered. They only reach the display registers at
//   a frame boundary, so a displayed frame never mixes two values.
//
// Parameters:
//   TICK_DIV  CLK cycles per digit slot (>= 2)
//   CNT_W     prescaler width, 2**CNT_W >= TICK_DIV
//
// Ports:
//   CLK       in   system clock, rising edge
//   RESET_N   in   asynchronous active-low reset
//   VALUE_IN  in   16-bit value, digit k = VALUE_IN[4k+3:4k], digit 0 rightmost
//   DOTS_IN   in   decimal points, bit k belongs to digit k
//   LOAD      in   capture VALUE_IN/DOTS_IN for the next frame
//   BLANK_LZ  in   1 = suppress leading zeros
//   LOAD_ACK  out  one-cycle pulse when a captured value becomes displayed
//   BINARY    out  nibble of the active digit
//   SEGMENT   out  active digit index 0..3
//   DOT       out  decimal point of the active digit
//   BLANK     out  1 = force segments a-g off for the active digit
// ---------------------------------------------------------------------------
module display_scan_controller #(
    parameter int TICK_DIV = 100000,
    parameter int CNT_W    = 17
) (
    input  logic        CLK,
    input  logic        RESET_N,
    input  logic [15:0] VALUE_IN,
    input  logic [3:0]  DOTS_IN,
    input  logic        LOAD,
    input  logic        BLANK_LZ,
    output logic        LOAD_ACK,
    output logic [3:0]  BINARY,
    output logic [1:0]  SEGMENT,
    output logic        DOT,
    output logic        BLANK
);

    logic [CNT_W-1:0] cnt;
    logic [1:0]       seg;
    logic [15:0]      disp_val;
    logic [3:0]       disp_dots;
    logic [15:0]      pend_val;
    logic [3:0]       pend_dots;
    logic             pend_flag;
    logic             ack;
    logic             blank_lz_q;

    logic tick;
    logic boundary;

    assign tick     = (cnt == CNT_W'(TICK_DIV - 1));
    assign boundary = tick && (seg == 2'd3);

    // Prescaler and digit index.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            cnt <= '0;
            seg <= 2'd0;
        end else begin
            if (tick) begin
                cnt <= '0;
                seg <= seg + 2'd1;
            end else begin
                cnt <= cnt + CNT_W'(1);
            end
        end
    end

    // Double buffer. A LOAD coinciding with the boundary bypasses the pending
    // registers so that the most recent request always wins.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            disp_val  <= '0;
            disp_dots <= '0;
            pend_val  <= '0;
            pend_dots <= '0;
            pend_flag <= 1'b0;
            ack       <= 1'b0;
        end else begin
            ack <= 1'b0;
            if (boundary) begin
                if (LOAD) begin
                    disp_val  <= VALUE_IN;
                    disp_dots <= DOTS_IN;
                    ack       <= 1'b1;
                end else if (pend_flag) begin
                    disp_val  <= pend_val;
                    disp_dots <= pend_dots;
                    ack       <= 1'b1;
                end
                pend_flag <= 1'b0;
            end else if (LOAD) begin
                pend_val  <= VALUE_IN;
                pend_dots <= DOTS_IN;
                pend_flag <= 1'b1;
            end
        end
    end

    // BLANK_LZ is registered so that no input reaches an output combinationally.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            blank_lz_q <= 1'b0;
        end else begin
            blank_lz_q <= BLANK_LZ;
        end
    end

    // Output decode from registered state only.
    assign SEGMENT  = seg;
    assign LOAD_ACK = ack;
    assign BINARY   = disp_val[{seg, 2'b00} +: 4];
    assign DOT      = disp_dots[seg];

    // Digit k is a leading zero when nibbles k..3 are all zero; digit 0 always shows.
    always_comb begin
        BLANK = 1'b0;
        if (blank_lz_q) begin
            case (seg)
                2'd1:    BLANK = (disp_val[15:4]  == 12'd0);
                2'd2:    BLANK = (disp_val[15:8]  == 8'd0);
                2'd3:    BLANK = (disp_val[15:12] == 4'd0);
                default: BLANK = 1'b0;
            endcase
        end
    end

endmodule
